// File: rtl/pic_seq_pkg.sv
// Shared types and constants for the 8259 host-side bus sequencer.
// Holds the FSM encoding, ICW/OCW bit positions and the init write ordering.
package pic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_LOW,
        ST_WR_GAP,
        ST_ACK1_LOW,
        ST_ACK1_GAP,
        ST_ACK2_LOW,
        ST_ACK2_GAP
    } state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_INIT = 4;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;

    localparam logic [7:0] OCW2_NS_EOI = 8'h20;

    localparam logic [2:0] IDX_ICW1 = 3'd0;
    localparam logic [2:0] IDX_ICW2 = 3'd1;
    localparam logic [2:0] IDX_ICW3 = 3'd2;
    localparam logic [2:0] IDX_ICW4 = 3'd3;
    localparam logic [2:0] IDX_OCW1 = 3'd4;

    typedef struct packed {
        logic       ltim;
        logic       sngl;
        logic       ic4;
        logic [4:0] vec_base;
        logic [7:0] icw3;
        logic       aeoi;
        logic       ms;
        logic       buf_mode;
        logic [7:0] mask;
    } cfg_t;

    // ICW3 is skipped in single mode, ICW4 when IC4 is clear; OCW1 always ends the list.
    function automatic logic [2:0] next_wr_idx(input logic [2:0] idx,
                                               input logic       sngl,
                                               input logic       ic4);
        logic [2:0] nxt;
        case (idx)
            IDX_ICW1: nxt = IDX_ICW2;
            IDX_ICW2: nxt = !sngl ? IDX_ICW3 : (ic4 ? IDX_ICW4 : IDX_OCW1);
            IDX_ICW3: nxt = ic4 ? IDX_ICW4 : IDX_OCW1;
            default:  nxt = IDX_OCW1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/pic_host_sequencer_timer.sv
// Phase length timer: reloads with the pulse or gap length on each phase entry
// and flags the final cycle of the phase.
module pic_strobe_timer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_sel_pulse,
    output logic o_last
);

    localparam logic [3:0] PULSE_RELOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_RELOAD   = 4'(GAP_CYCLES - 1);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_sel_pulse ? PULSE_RELOAD : GAP_RELOAD;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_last = (r_count == 4'd0);

endmodule

// File: rtl/pic_host_sequencer.sv
// Host-side sequencer driving the 8259 bus pins: init write list, non-specific
// EOI writes and the two-pulse INTA acknowledge with vector capture.
module pic_host_sequencer
    import pic_seq_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_start,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic [4:0] cfg_vec_base,
    input  logic [7:0] cfg_icw3,
    input  logic       cfg_aeoi,
    input  logic       cfg_ms,
    input  logic       cfg_buf,
    input  logic [7:0] cfg_mask,
    output logic       cfg_busy,
    output logic       cfg_done,
    output logic       configured,
    input  logic       eoi_req,
    output logic       eoi_done,
    input  logic       ack_enable,
    input  logic       INT,
    output logic       vec_valid,
    output logic [7:0] vec_out,
    output logic       WD,
    output logic       RD,
    output logic       A0,
    output logic       INTA,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    state_t     r_state;
    state_t     w_state_next;
    cfg_t       r_cfg;
    logic [2:0] r_wr_idx;
    logic       r_is_eoi;
    logic       r_configured;
    logic       r_vec_valid;
    logic [7:0] r_vec;

    logic       w_last;
    logic       w_load;
    logic       w_sel_pulse;
    logic       w_accept_cfg;
    logic       w_accept_eoi;
    logic       w_last_write;
    logic       w_write_done;
    logic       w_vec_capture;
    logic       w_writing;
    logic       w_wr_a0;
    logic [7:0] w_wr_data;

    // Every transition enters a new phase, so a state change is the reload trigger.
    assign w_load      = (w_state_next != r_state);
    assign w_sel_pulse = (w_state_next == ST_WR_LOW) || (w_state_next == ST_ACK1_LOW) ||
                         (w_state_next == ST_ACK2_LOW);

    pic_strobe_timer #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_sel_pulse (w_sel_pulse),
        .o_last      (w_last)
    );

    assign w_last_write  = r_is_eoi || (r_wr_idx == IDX_OCW1);
    assign w_write_done  = (r_state == ST_WR_GAP) && w_last;
    assign w_vec_capture = (r_state == ST_ACK2_LOW) && w_last;
    assign w_writing     = (r_state == ST_WR_LOW) || (r_state == ST_WR_GAP);

    always_comb begin
        w_state_next = r_state;
        w_accept_cfg = 1'b0;
        w_accept_eoi = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_start) begin
                    w_state_next = ST_WR_LOW;
                    w_accept_cfg = 1'b1;
                end else if (eoi_req && r_configured) begin
                    w_state_next = ST_WR_LOW;
                    w_accept_eoi = 1'b1;
                end else if (INT && ack_enable && r_configured) begin
                    w_state_next = ST_ACK1_LOW;
                end
            end
            ST_WR_LOW:   if (w_last) w_state_next = ST_WR_GAP;
            ST_WR_GAP:   if (w_last) w_state_next = w_last_write ? ST_IDLE : ST_WR_LOW;
            ST_ACK1_LOW: if (w_last) w_state_next = ST_ACK1_GAP;
            ST_ACK1_GAP: if (w_last) w_state_next = ST_ACK2_LOW;
            ST_ACK2_LOW: if (w_last) w_state_next = ST_ACK2_GAP;
            ST_ACK2_GAP: if (w_last) w_state_next = ST_IDLE;
            default:     w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cfg        <= '0;
            r_wr_idx     <= IDX_ICW1;
            r_is_eoi     <= 1'b0;
            r_configured <= 1'b0;
            r_vec_valid  <= 1'b0;
            r_vec        <= 8'h00;
        end else begin
            r_state     <= w_state_next;
            r_vec_valid <= w_vec_capture;
            if (w_accept_cfg) begin
                r_cfg    <= '{ltim: cfg_ltim, sngl: cfg_sngl, ic4: cfg_ic4,
                              vec_base: cfg_vec_base, icw3: cfg_icw3, aeoi: cfg_aeoi,
                              ms: cfg_ms, buf_mode: cfg_buf, mask: cfg_mask};
                r_wr_idx <= IDX_ICW1;
                r_is_eoi <= 1'b0;
            end else if (w_accept_eoi) begin
                r_is_eoi <= 1'b1;
            end else if (w_write_done && !w_last_write) begin
                r_wr_idx <= next_wr_idx(r_wr_idx, r_cfg.sngl, r_cfg.ic4);
            end
            if (cfg_done) begin
                r_configured <= 1'b1;
            end
            if (w_vec_capture) begin
                r_vec <= data_in;
            end
        end
    end

    always_comb begin
        w_wr_data = 8'h00;
        w_wr_a0   = 1'b1;
        if (r_is_eoi) begin
            w_wr_data = OCW2_NS_EOI;
            w_wr_a0   = 1'b0;
        end else begin
            case (r_wr_idx)
                IDX_ICW1: begin
                    w_wr_a0              = 1'b0;
                    w_wr_data[ICW1_INIT] = 1'b1;
                    w_wr_data[ICW1_LTIM] = r_cfg.ltim;
                    w_wr_data[ICW1_SNGL] = r_cfg.sngl;
                    w_wr_data[ICW1_IC4]  = r_cfg.ic4;
                end
                IDX_ICW2: w_wr_data = {r_cfg.vec_base, 3'b000};
                IDX_ICW3: w_wr_data = r_cfg.icw3;
                IDX_ICW4: begin
                    w_wr_data[ICW4_UPM]  = 1'b1;
                    w_wr_data[ICW4_AEOI] = r_cfg.aeoi;
                    w_wr_data[ICW4_MS]   = r_cfg.ms;
                    w_wr_data[ICW4_BUF]  = r_cfg.buf_mode;
                end
                default:  w_wr_data = r_cfg.mask;
            endcase
        end
    end

    assign WD         = (r_state != ST_WR_LOW);
    assign RD         = (r_state != ST_ACK2_LOW);
    assign INTA       = !((r_state == ST_ACK1_LOW) || (r_state == ST_ACK2_LOW));
    assign A0         = w_writing && w_wr_a0;
    assign data_out   = w_writing ? w_wr_data : 8'h00;
    assign data_oe    = w_writing;
    assign cfg_busy   = w_writing && !r_is_eoi;
    assign cfg_done   = w_write_done && w_last_write && !r_is_eoi;
    assign eoi_done   = w_write_done && r_is_eoi;
    assign configured = r_configured;
    assign vec_valid  = r_vec_valid;
    assign vec_out    = r_vec;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// Self-checking bench: table-driven init sequences, directed corner cases and
// randomized requests compared against a transaction-level model of the bus.
module tb_pic_host_sequencer;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_start, cfg_ltim, cfg_sngl, cfg_ic4, cfg_aeoi, cfg_ms, cfg_buf;
    logic [4:0] cfg_vec_base;
    logic [7:0] cfg_icw3, cfg_mask;
    logic       cfg_busy, cfg_done, configured;
    logic       eoi_req, eoi_done, ack_enable, INT, vec_valid;
    logic [7:0] vec_out;
    logic       WD, RD, A0, INTA, data_oe;
    logic [7:0] data_out, data_in;

    int errors = 0;
    int checks = 0;
    bit m_conf = 1'b0;

    typedef struct {
        logic             ltim;
        logic             sngl;
        logic             ic4;
        logic [4:0]       vb;
        logic [7:0]       icw3;
        logic             aeoi;
        logic             ms;
        logic             bufm;
        logic [7:0]       mask;
        int               n;
        logic [4:0]       a0s;
        logic [4:0][7:0]  ds;
    } vec_t;

    vec_t tab[4];

    pic_host_sequencer #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_ltim(cfg_ltim),
        .cfg_sngl(cfg_sngl), .cfg_ic4(cfg_ic4), .cfg_vec_base(cfg_vec_base),
        .cfg_icw3(cfg_icw3), .cfg_aeoi(cfg_aeoi), .cfg_ms(cfg_ms), .cfg_buf(cfg_buf),
        .cfg_mask(cfg_mask), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
        .configured(configured), .eoi_req(eoi_req), .eoi_done(eoi_done),
        .ack_enable(ack_enable), .INT(INT), .vec_valid(vec_valid), .vec_out(vec_out),
        .WD(WD), .RD(RD), .A0(A0), .INTA(INTA), .data_out(data_out),
        .data_oe(data_oe), .data_in(data_in)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected init write list derived from the ICW/OCW field rules.
    function automatic void model_cfg(inout vec_t r);
        logic [7:0] q[$];
        logic       qa[$];
        q.push_back(8'h10 + (r.ltim ? 8'h08 : 8'h00) + (r.sngl ? 8'h02 : 8'h00) +
                    (r.ic4 ? 8'h01 : 8'h00));
        qa.push_back(1'b0);
        q.push_back(8'({3'b000, r.vb}) * 8'd8);
        qa.push_back(1'b1);
        if (!r.sngl) begin
            q.push_back(r.icw3);
            qa.push_back(1'b1);
        end
        if (r.ic4) begin
            q.push_back(8'h01 + (r.bufm ? 8'h08 : 8'h00) + (r.ms ? 8'h04 : 8'h00) +
                        (r.aeoi ? 8'h02 : 8'h00));
            qa.push_back(1'b1);
        end
        q.push_back(r.mask);
        qa.push_back(1'b1);
        r.n   = q.size();
        r.a0s = '0;
        r.ds  = '0;
        for (int i = 0; i < q.size(); i++) begin
            r.a0s[i] = qa[i];
            r.ds[i]  = q[i];
        end
    endfunction

    task automatic set_cfg(input vec_t r);
        cfg_ltim = r.ltim; cfg_sngl = r.sngl; cfg_ic4 = r.ic4; cfg_vec_base = r.vb;
        cfg_icw3 = r.icw3; cfg_aeoi = r.aeoi; cfg_ms = r.ms; cfg_buf = r.bufm;
        cfg_mask = r.mask;
    endtask

    task automatic scramble_cfg();
        cfg_ltim = 1'($urandom); cfg_sngl = 1'($urandom); cfg_ic4 = 1'($urandom);
        cfg_vec_base = 5'($urandom); cfg_icw3 = 8'($urandom); cfg_aeoi = 1'($urandom);
        cfg_ms = 1'($urandom); cfg_buf = 1'($urandom); cfg_mask = 8'($urandom);
    endtask

    // Entered at the negedge of the first WD-low cycle; leaves at the idle negedge.
    task automatic check_writes(input int n, input logic [4:0] a0s,
                                input logic [4:0][7:0] ds, input bit is_eoi);
        for (int w = 0; w < n; w++) begin
            for (int c = 0; c < P + G; c++) begin
                bit lastc;
                lastc = (w == n - 1) && (c == P + G - 1);
                if (!is_eoi && w == 0 && c == 0) scramble_cfg();
                chk("wr_wd", 32'(WD), (c < P) ? 32'd0 : 32'd1);
                chk("wr_a0", 32'(A0), 32'(a0s[w]));
                chk("wr_data", 32'(data_out), 32'(ds[w]));
                chk("wr_oe", 32'(data_oe), 32'd1);
                chk("wr_inta_rd", 32'({INTA, RD}), 32'd3);
                chk("wr_busy", 32'(cfg_busy), 32'(!is_eoi));
                chk("wr_cfg_done", 32'(cfg_done), 32'(!is_eoi && lastc));
                chk("wr_eoi_done", 32'(eoi_done), 32'(is_eoi && lastc));
                chk("wr_configured", 32'(configured), 32'(m_conf));
                if (is_eoi && lastc) eoi_req = 1'b0;
                @(negedge clk);
            end
            $display("write %0d: a0=%0b data=%02h eoi=%0b", w, a0s[w], ds[w], is_eoi);
        end
        if (!is_eoi) m_conf = 1'b1;
        chk("idle_wd", 32'(WD), 32'd1);
        chk("idle_oe", 32'(data_oe), 32'd0);
        chk("idle_busy", 32'(cfg_busy), 32'd0);
        chk("idle_configured", 32'(configured), 32'(m_conf));
    endtask

    task automatic run_cfg(input vec_t r);
        set_cfg(r);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check_writes(r.n, r.a0s, r.ds, 1'b0);
    endtask

    // Entered at the negedge of the first ACK1_LOW cycle; leaves at the idle negedge.
    task automatic run_ack(input logic [7:0] vec, input bit drop_int);
        for (int c = 0; c < 2 * P + 2 * G; c++) begin
            logic exp_inta, exp_rd;
            if (c == 0 && drop_int) INT = 1'b0;
            exp_inta = !((c < P) || (c >= P + G && c < 2 * P + G));
            exp_rd   = !(c >= P + G && c < 2 * P + G);
            data_in  = exp_rd ? 8'($urandom) : vec;
            chk("ack_inta", 32'(INTA), 32'(exp_inta));
            chk("ack_rd", 32'(RD), 32'(exp_rd));
            chk("ack_wd_oe", 32'({WD, data_oe}), 32'd2);
            chk("ack_vec_valid", 32'(vec_valid), 32'(c == 2 * P + G));
            @(negedge clk);
        end
        data_in = 8'($urandom);
        chk("ack_vec_out", 32'(vec_out), 32'(vec));
        chk("ack_idle_inta", 32'(INTA), 32'd1);
        chk("ack_idle_valid", 32'(vec_valid), 32'd0);
        $display("ack: vector=%02h", vec);
    endtask

    initial begin
        vec_t r;
        logic [7:0] v;

        tab[0] = '{1'b0, 1'b1, 1'b0, 5'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'hF0, 3, 5'b00110,
                   {8'h00, 8'h00, 8'hF0, 8'h40, 8'h12}};
        tab[1] = '{1'b0, 1'b0, 1'b1, 5'h08, 8'h04, 1'b1, 1'b1, 1'b1, 8'hF0, 5, 5'b11110,
                   {8'hF0, 8'h0F, 8'h04, 8'h40, 8'h11}};
        tab[2] = '{1'b1, 1'b0, 1'b0, 5'h1F, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 4, 5'b01110,
                   {8'h00, 8'h00, 8'h80, 8'hF8, 8'h18}};
        tab[3] = '{1'b1, 1'b1, 1'b1, 5'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 4, 5'b01110,
                   {8'h00, 8'h5A, 8'h09, 8'h08, 8'h1B}};

        rst = 1'b1; cfg_start = 1'b0; eoi_req = 1'b0; ack_enable = 1'b0; INT = 1'b0;
        data_in = 8'h00;
        set_cfg(tab[0]);
        repeat (3) @(negedge clk);
        chk("rst_strobes", 32'({WD, RD, INTA}), 32'd7);
        chk("rst_a0", 32'(A0), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_oe", 32'(data_oe), 32'd0);
        chk("rst_cfg", 32'({cfg_busy, cfg_done, configured}), 32'd0);
        chk("rst_pulses", 32'({eoi_done, vec_valid}), 32'd0);
        chk("rst_vec", 32'(vec_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Requests before configuration produce no strobes.
        eoi_req = 1'b1; INT = 1'b1; ack_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("precfg_strobes", 32'({WD, RD, INTA}), 32'd7);
            chk("precfg_busy", 32'(cfg_busy), 32'd0);
        end
        // cfg_start wins, then the pending EOI, then the ACK.
        run_cfg(tab[0]);
        @(negedge clk);
        check_writes(1, 5'b00000, {32'h0, OCW2_NS_EOI_TB()}, 1'b1);
        chk("eoi_then_idle", 32'({WD, INTA}), 32'd3);
        @(negedge clk);
        run_ack(8'h43, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_ack_int_low", 32'(INTA), 32'd1);
        end

        for (int i = 1; i < 4; i++) run_cfg(tab[i]);

        // Reset in the second ICW2 WD-low cycle abandons the sequence.
        set_cfg(tab[0]);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_icw2_wd", 32'(WD), 32'd0);
        chk("mid_icw2_data", 32'(data_out), 32'h40);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_conf = 1'b0;
        chk("midrst_wd", 32'(WD), 32'd1);
        chk("midrst_oe", 32'(data_oe), 32'd0);
        chk("midrst_busy", 32'(cfg_busy), 32'd0);
        chk("midrst_configured", 32'(configured), 32'd0);
        chk("midrst_a0_data", 32'({A0, data_out}), 32'd0);
        run_cfg(tab[0]);

        // EOI and INT rising together: EOI first, ACK immediately after.
        eoi_req = 1'b1; INT = 1'b1; ack_enable = 1'b1;
        @(negedge clk);
        check_writes(1, 5'b00000, {32'h0, OCW2_NS_EOI_TB()}, 1'b1);
        chk("eoi_int_idle", 32'(INTA), 32'd1);
        @(negedge clk);
        run_ack(8'hA7, 1'b1);

        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    r = tab[0];
                    r.ltim = 1'($urandom); r.sngl = 1'($urandom); r.ic4 = 1'($urandom);
                    r.vb = 5'($urandom); r.icw3 = 8'($urandom); r.aeoi = 1'($urandom);
                    r.ms = 1'($urandom); r.bufm = 1'($urandom); r.mask = 8'($urandom);
                    model_cfg(r);
                    run_cfg(r);
                end
                1: begin
                    eoi_req = 1'b1;
                    @(negedge clk);
                    check_writes(1, 5'b00000, {32'h0, OCW2_NS_EOI_TB()}, 1'b1);
                end
                2: begin
                    v = 8'($urandom);
                    INT = 1'b1; ack_enable = 1'b1;
                    @(negedge clk);
                    run_ack(v, 1'b1);
                end
                default: begin
                    INT = 1'b1; ack_enable = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        chk("ack_disabled", 32'({INTA, RD}), 32'd3);
                    end
                    INT = 1'b0; ack_enable = 1'b1;
                    @(negedge clk);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [7:0] OCW2_NS_EOI_TB();
        return 8'h20;
    endfunction

endmodule
